// File: rtl/fp18_pkg.sv
// rtl/fp18_pkg.sv - shared widths, state encoding and field helpers for the fp18 multiplier
package fp18_pkg;

  localparam int EXP_W  = 7;
  localparam int MAN_W  = 10;
  localparam int BIAS   = 63;
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int PROD_W = 2 * MAN_W + 2;
  localparam int ESUM_W = EXP_W + 2;
  localparam int CNT_W  = $clog2(MAN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic f_sign(input logic [W-1:0] x);
    return x[W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
    return x[W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp18_shift_add_mul.sv
// rtl/fp18_shift_add_mul.sv - iterative unsigned shift-add mantissa multiplier, one bit per cycle
module fp18_shift_add_mul
  import fp18_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MAN_W:0]        mcand,
  input  logic [MAN_W:0]        mplier,
  output logic [PROD_W-MAN_W-1:0] product_hi,
  output logic                  done
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand_q;
  logic [MAN_W:0]    mplier_q;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  // Load on start, then consume one multiplier bit (LSB first) per cycle; the
  // multiplicand shifts left alongside so no variable shifter is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      mcand_q  <= PROD_W'(mcand);
      mplier_q <= mplier;
      cnt      <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      if (mplier_q[0]) begin
        acc <= acc + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt == CNT_W'(MAN_W)) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // done marks the cycle whose closing edge performs the final step.
  assign done = busy && (cnt == CNT_W'(MAN_W));

  // Truncating normalisation only ever looks at the upper bits of the product.
  assign product_hi = acc[PROD_W-1:MAN_W];

endmodule

// File: rtl/fp18_mul_core.sv
// rtl/fp18_mul_core.sv - multi-cycle 18-bit floating-point multiplier with valid/ready handshake
module fp18_mul_core
  import fp18_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf
);

  localparam logic signed [ESUM_W-1:0] E_MAX  = ESUM_W'((1 << EXP_W) - 2);
  localparam logic signed [ESUM_W-1:0] E_MIN  = ESUM_W'(1);
  localparam logic signed [ESUM_W-1:0] E_BIAS = ESUM_W'(BIAS);

  state_t state;
  state_t next_state;

  logic                       start;
  logic                       mul_done;
  logic [PROD_W-MAN_W-1:0]    product_hi;
  logic                       sign_q;
  logic                       zero_q;
  logic signed [ESUM_W-1:0]   esum_q;
  logic signed [ESUM_W-1:0]   e_norm;
  logic [MAN_W-1:0]           man_norm;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign start     = (state == IDLE) && in_valid;

  fp18_shift_add_mul u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mcand      ({1'b1, f_man(a)}),
    .mplier     ({1'b1, f_man(b)}),
    .product_hi (product_hi),
    .done       (mul_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: accept in IDLE, wait out the multiplier, one normalise cycle, hold until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = MUL;
      MUL:     if (mul_done)  next_state = NORM;
      NORM:                   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Capture sign, biased exponent sum and zero-operand flag at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      esum_q <= '0;
    end else if (start) begin
      sign_q <= f_sign(a) ^ f_sign(b);
      zero_q <= (f_exp(a) == '0) || (f_exp(b) == '0);
      esum_q <= $signed({2'b00, f_exp(a)}) + $signed({2'b00, f_exp(b)}) - E_BIAS;
    end
  end

  // Normalise: a product in [2,4) shifts one place right and bumps the exponent.
  always_comb begin
    e_norm   = esum_q;
    man_norm = product_hi[MAN_W-1:0];
    if (product_hi[PROD_W-MAN_W-1]) begin
      e_norm   = esum_q + ESUM_W'(1);
      man_norm = product_hi[PROD_W-MAN_W-2 -: MAN_W];
    end
  end

  // Register result and flags in NORM; zero operand wins over overflow, which wins over underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (state == NORM) begin
      if (zero_q) begin
        result <= {sign_q, {(W-1){1'b0}}};
        ovf    <= 1'b0;
        unf    <= 1'b1;
      end else if (e_norm > E_MAX) begin
        result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        ovf    <= 1'b1;
        unf    <= 1'b0;
      end else if (e_norm < E_MIN) begin
        result <= {sign_q, {(W-1){1'b0}}};
        ovf    <= 1'b0;
        unf    <= 1'b1;
      end else begin
        result <= {sign_q, e_norm[EXP_W-1:0], man_norm};
        ovf    <= 1'b0;
        unf    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp18_mul_core.sv
// tb/tb_fp18_mul_core.sv - self-checking bench for fp18_mul_core
module tb_fp18_mul_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] a;
  logic [17:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] result;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp18_mul_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: real-valued meaning of the format, evaluated with integer arithmetic.
  function automatic void ref_mul(input logic [17:0] x, input logic [17:0] y,
                                  output logic [17:0] r, output logic ro, output logic ru);
    int ex, ey, e, man;
    longint p;
    logic s;
    logic [31:0] ev;
    s  = x[17] ^ y[17];
    ex = int'(x[16:10]);
    ey = int'(y[16:10]);
    ro = 1'b0;
    ru = 1'b0;
    if (ex == 0 || ey == 0) begin
      r  = {s, 17'd0};
      ru = 1'b1;
      return;
    end
    p = longint'(1024 + int'(x[9:0])) * longint'(1024 + int'(y[9:0]));
    e = ex + ey - 63;
    if (p >= 64'd2097152) begin
      e = e + 1;
      p = p / 2;
    end
    man = int'(p / 1024) - 1024;
    if (e > 126) begin
      r  = {s, 7'h7f, 10'd0};
      ro = 1'b1;
    end else if (e < 1) begin
      r  = {s, 17'd0};
      ru = 1'b1;
    end else begin
      ev = 32'(e);
      r  = {s, ev[6:0], 10'(man)};
    end
  endfunction

  // Called #1 after the accept edge; counts edges (accept inclusive) until out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_out(input string tag, input int n, input logic [17:0] er,
                           input logic eo, input logic eu);
    chk({tag, "_latency"}, 32'(n), 32'd13);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_unf"}, 32'(unf), 32'(eu));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_outvalid_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_inready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [17:0] x, input logic [17:0] y,
                       input logic [17:0] er, input logic eo, input logic eu);
    int n;
    @(negedge clk);
    chk({tag, "_inready"}, 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 18'($urandom);
    b = 18'($urandom);
    wait_valid(n);
    check_out(tag, n, er, eo, eu);
    release_out(tag);
  endtask

  initial begin
    logic [17:0] x, y, er;
    logic eo, eu;
    int n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("rst_inready", 32'(in_ready), 32'd1);
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {30'd0, ovf, unf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("one_x_one", 18'h0FC00, 18'h0FC00, 18'h0FC00, 1'b0, 1'b0);
    do_op("1p5_sq", 18'h0FE00, 18'h0FE00, 18'h10080, 1'b0, 1'b0);
    do_op("neg2_x_1p5", 18'h30000, 18'h0FE00, 18'h30200, 1'b0, 1'b0);
    do_op("overflow", 18'h1F800, 18'h1F800, 18'h1FC00, 1'b1, 1'b0);
    do_op("underflow", 18'h00400, 18'h00400, 18'h00000, 1'b0, 1'b1);
    do_op("zero_op", 18'h00000, 18'h0FC00, 18'h00000, 1'b0, 1'b1);
    do_op("neg_zero", 18'h20000, 18'h0FC00, 18'h20000, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      x = {1'($urandom), (i % 4 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(30, 95)),
           10'($urandom)};
      y = {1'($urandom), (i % 5 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(30, 95)),
           10'($urandom)};
      ref_mul(x, y, er, eo, eu);
      do_op("rand", x, y, er, eo, eu);
    end

    // Back-pressure in DONE with new operands presented throughout.
    @(negedge clk);
    a = 18'h0FE00;
    b = 18'h0FE00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    check_out("stall", n, 18'h10080, 1'b0, 1'b0);
    a = 18'h0FC00;
    b = 18'h30000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_result", 32'(result), 32'h10080);
      chk("stall_outvalid", 32'(out_valid), 32'd1);
      chk("stall_inready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall_rel_idle", 32'(in_ready), 32'd1);
    chk("stall_rel_outvalid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("next_accepted", 32'(in_ready), 32'd0);
    wait_valid(n);
    check_out("after_stall", n, 18'h30000, 1'b0, 1'b0);
    release_out("after_stall");

    // Asynchronous reset in the middle of MUL.
    @(negedge clk);
    a = 18'h1F800;
    b = 18'h1F800;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_outvalid", 32'(out_valid), 32'd0);
    chk("midrst_inready", 32'(in_ready), 32'd1);
    chk("midrst_flags", {30'd0, ovf, unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 18'h0FE00, 18'h0FC00, 18'h0FE00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
